zesal_arbiter: RTL and testbench
================================

Name: zesal_arbiter

Overview:
Round-robin arbiter and sequencer sharing one Zesal node between REQUESTERS independent clients. Accepts one command at a time (opcode + argument) over valid/ready, issues it to the node, waits the node's fixed result latency, and returns the result to the owning requester. Rejects out-of-range opcodes locally without touching the node. Sits directly in front of a Zesal node instance.

Parameters:
REQUESTERS, 4, number of clients; must be ≥2.
OP_BITS, 5, opcode width; valid opcodes are 1..30 (Reset..And).
ARG_BITS, 32, command argument width (packed index/key/data as the node expects).
RESULT_BITS, 32, node result width.
LATENCY, 1, node cycles from node_valid to node_result valid; must be ≥1.

Ports:
clock  input  1  system clock, all state on rising edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  REQUESTERS  per-client command valid.
req_ready  output  REQUESTERS  per-client accept, at most one bit high.
req_op  input  REQUESTERS*OP_BITS  client i opcode at bits [i*OP_BITS +: OP_BITS].
req_arg  input  REQUESTERS*ARG_BITS  client i argument, packed the same way.
node_valid  output  1  one-cycle command strobe to node.
node_op  output  OP_BITS  opcode to node.
node_arg  output  ARG_BITS  argument to node.
node_result  input  RESULT_BITS  node result, valid LATENCY cycles after node_valid.
rsp_valid  output  REQUESTERS  per-client response valid, at most one bit high.
rsp_ready  input  REQUESTERS  per-client response accept.
rsp_data  output  RESULT_BITS  response payload, shared by all clients.
rsp_error  output  1  response is a rejection (invalid opcode).
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE, rr pointer=0, req_ready=0, node_valid=0, node_op=0, node_arg=0, rsp_valid=0, rsp_data=0, rsp_error=0, busy=0. Any in-flight command is dropped. A node result arriving after reset is ignored.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE arbitration: scan requesters from index ptr upward, modulo REQUESTERS. The first one with req_valid=1 is the grant, and only its req_ready is 1 (combinational from registered state and req_valid). If there is no valid request, all req_ready=0.
- Acceptance in cycle t: latch op, arg and owner; set ptr=(owner+1) mod REQUESTERS.
  - Opcode in 1..30: go to ISSUE.
  - Otherwise: go to RESPOND with rsp_error=1 and rsp_data=0. rsp_valid[owner] rises in t+1. The node is never driven.
- ISSUE (cycle t+1): node_valid=1, with node_op and node_arg from the latched values. Load the wait counter with LATENCY. Go to WAIT.
- WAIT: decrement the counter each cycle. On the edge ending cycle t+1+LATENCY, capture node_result into rsp_data, set rsp_error=0, and go to RESPOND. rsp_valid[owner] rises in cycle t+2+LATENCY.
- node_valid is high for exactly one cycle per issued command. node_op and node_arg hold their values until the next ISSUE.
- RESPOND:
  - rsp_valid[owner]=1, with rsp_data and rsp_error stable.
  - Stays until rsp_ready[owner]=1. rsp_ready of other clients is ignored.
  - On handshake: rsp_valid=0, go to IDLE. No new request is accepted in the handshake cycle, so the earliest next accept is the following cycle.
- Only one command is outstanding at a time; the node is never issued back-to-back commands.
- req_valid dropped before acceptance: no effect, the request is simply not granted. Request fields may change while req_ready=0.
- Simultaneous requests: strict round robin, so every requester with req_valid held is granted within REQUESTERS commands.
- ptr wraps from REQUESTERS-1 to 0.

Test Plan:
1. Reset mid-WAIT: client 0 issues op=3 (Read); assert reset during WAIT → all outputs 0 immediately (asynchronous). After reset releases, node_result=0x55 is never delivered and busy=0.
2. Single Read, LATENCY=1: client 2 issues op=3, arg=0x10 at t; node returns 0xAB at t+2 → node_valid=1 only at t+1; rsp_valid=4'b0100 and rsp_data=0xAB from t+3; cleared the cycle after rsp_ready[2]=1.
3. Round robin: all four clients hold op=4 (Size) continuously with rsp_ready=1 → grants in order 0,1,2,3,0. Then only clients 1 and 3 hold requests → grants 1,3,1,3.
4. Invalid opcodes 0 and 31 from client 1 → rsp_valid[1] the cycle after acceptance, rsp_error=1, rsp_data=0, node_valid never pulses.
5. Response back-pressure: client 3 holds rsp_ready=0 for 5 cycles while client 0 requests → rsp_valid[3], rsp_data and rsp_error stay stable; req_ready[0] stays 0 until the cycle after the client 3 handshake.
6. LATENCY=4 build: Write op=2 at t → node_valid at t+1; result captured from cycle t+5; rsp_valid from t+6; busy high t+1..handshake.

Source files
------------

// File: rtl/zesal_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared Zesal node.
// One command in flight at a time; invalid opcodes are answered locally with an error.
module zesal_arbiter #(
  parameter int REQUESTERS  = 4,
  parameter int OP_BITS     = 5,
  parameter int ARG_BITS    = 32,
  parameter int RESULT_BITS = 32,
  parameter int LATENCY     = 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [REQUESTERS-1:0]          req_valid,
  output logic [REQUESTERS-1:0]          req_ready,
  input  logic [REQUESTERS*OP_BITS-1:0]  req_op,
  input  logic [REQUESTERS*ARG_BITS-1:0] req_arg,
  output logic                           node_valid,
  output logic [OP_BITS-1:0]             node_op,
  output logic [ARG_BITS-1:0]            node_arg,
  input  logic [RESULT_BITS-1:0]         node_result,
  output logic [REQUESTERS-1:0]          rsp_valid,
  input  logic [REQUESTERS-1:0]          rsp_ready,
  output logic [RESULT_BITS-1:0]         rsp_data,
  output logic                           rsp_error,
  output logic                           busy
);

  localparam int PTR_W = $clog2(REQUESTERS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_owner;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_node_valid;
  logic [OP_BITS-1:0]      r_node_op;
  logic [ARG_BITS-1:0]     r_node_arg;
  logic [REQUESTERS-1:0]   r_rsp_valid;
  logic [RESULT_BITS-1:0]  r_rsp_data;
  logic                    r_rsp_error;
  logic                    r_busy;

  logic                    w_grant_any;
  logic [PTR_W-1:0]        w_grant_idx;
  logic [PTR_W-1:0]        w_scan_idx;
  logic [OP_BITS-1:0]      w_op_sel;
  logic [ARG_BITS-1:0]     w_arg_sel;
  logic                    w_op_ok;
  logic                    w_accept;
  logic                    w_rsp_done;
  logic [PTR_W-1:0]        w_ptr_next;
  int                      w_sum;

  function automatic logic [REQUESTERS-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [REQUESTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan from the round-robin pointer upward and mux the winner's command fields.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_scan_idx  = '0;
    w_sum       = 0;
    w_op_sel    = '0;
    w_arg_sel   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      w_sum = int'(r_ptr) + i;
      if (w_sum >= REQUESTERS) begin
        w_sum = w_sum - REQUESTERS;
      end else begin
        w_sum = w_sum;
      end
      w_scan_idx = PTR_W'(w_sum);
      if (!w_grant_any && req_valid[w_scan_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_scan_idx;
      end else begin
        w_grant_any = w_grant_any;
      end
    end
    for (int i = 0; i < REQUESTERS; i++) begin
      if (w_grant_idx == PTR_W'(i)) begin
        w_op_sel  = req_op[i*OP_BITS +: OP_BITS];
        w_arg_sel = req_arg[i*ARG_BITS +: ARG_BITS];
      end else begin
        w_op_sel  = w_op_sel;
      end
    end
  end

  assign w_accept   = (r_state == S_IDLE) && w_grant_any;
  assign w_op_ok    = (w_op_sel >= OP_BITS'(1)) && (w_op_sel <= OP_BITS'(30));
  assign w_rsp_done = (r_state == S_RESPOND) && |(r_rsp_valid & rsp_ready);
  assign w_ptr_next = (w_grant_idx == PTR_W'(REQUESTERS - 1)) ? '0 : w_grant_idx + PTR_W'(1);
  assign req_ready  = w_accept ? onehot(w_grant_idx) : '0;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_op_ok ? S_ISSUE : S_RESPOND;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_RESPOND;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_RESPOND: begin
        if (w_rsp_done) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESPOND;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Command latch, node strobe, latency counter and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_node_valid <= 1'b0;
      r_node_op    <= '0;
      r_node_arg   <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_node_valid <= 1'b0;
      r_busy       <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner <= w_grant_idx;
            r_ptr   <= w_ptr_next;
            if (w_op_ok) begin
              r_node_valid <= 1'b1;
              r_node_op    <= w_op_sel;
              r_node_arg   <= w_arg_sel;
            end else begin
              r_rsp_data  <= '0;
              r_rsp_error <= 1'b1;
              r_rsp_valid <= onehot(w_grant_idx);
            end
          end
        end
        S_ISSUE: r_cnt <= CNT_W'(LATENCY);
        S_WAIT: begin
          // The node result is valid in the last WAIT cycle.
          if (r_cnt == CNT_W'(1)) begin
            r_rsp_data  <= node_result;
            r_rsp_error <= 1'b0;
            r_rsp_valid <= onehot(r_owner);
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESPOND: begin
          if (w_rsp_done) begin
            r_rsp_valid <= '0;
          end
        end
        default: r_rsp_valid <= '0;
      endcase
    end
  end

  assign node_valid = r_node_valid;
  assign node_op    = r_node_op;
  assign node_arg   = r_node_arg;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign rsp_error  = r_rsp_error;
  assign busy       = r_busy;

endmodule

// File: tb/tb_zesal_arbiter.sv
// Directed bench for zesal_arbiter: a LATENCY=1 instance and a LATENCY=4 instance
// share clock and reset, each fed by a small delay-line node model.
module tb_zesal_arbiter;

  logic         clock = 1'b0;
  logic         reset = 1'b1;

  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [19:0]  req_op = '0;
  logic [127:0] req_arg = '0;
  logic         node_valid;
  logic [4:0]   node_op;
  logic [31:0]  node_arg;
  logic [31:0]  node_result;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready = '0;
  logic [31:0]  rsp_data;
  logic         rsp_error;
  logic         busy;

  logic [3:0]   req_valid4 = '0;
  logic [3:0]   req_ready4;
  logic [19:0]  req_op4 = '0;
  logic [127:0] req_arg4 = '0;
  logic         node_valid4;
  logic [4:0]   node_op4;
  logic [31:0]  node_arg4;
  logic [31:0]  node_result4;
  logic [3:0]   rsp_valid4;
  logic [3:0]   rsp_ready4 = '0;
  logic [31:0]  rsp_data4;
  logic         rsp_error4;
  logic         busy4;

  logic [31:0]  val1 = 32'h0;
  logic [31:0]  val4 = 32'h0;
  logic         d1 = 1'b0;
  logic [3:0]   d4 = 4'b0;
  int           nv_count = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  always #5 clock = ~clock;

  // Node models: result is valid exactly LATENCY cycles after node_valid.
  always @(posedge clock) begin
    d1 <= node_valid;
    d4 <= {d4[2:0], node_valid4};
    if (node_valid === 1'b1) nv_count <= nv_count + 1;
  end
  assign node_result  = d1    ? val1 : 32'hDEAD_0001;
  assign node_result4 = d4[3] ? val4 : 32'hDEAD_0004;

  zesal_arbiter #(.REQUESTERS(4), .OP_BITS(5), .ARG_BITS(32), .RESULT_BITS(32), .LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_arg(req_arg),
    .node_valid(node_valid), .node_op(node_op), .node_arg(node_arg), .node_result(node_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .busy(busy)
  );

  zesal_arbiter #(.REQUESTERS(4), .OP_BITS(5), .ARG_BITS(32), .RESULT_BITS(32), .LATENCY(4)) dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid4), .req_ready(req_ready4), .req_op(req_op4), .req_arg(req_arg4),
    .node_valid(node_valid4), .node_op(node_op4), .node_arg(node_arg4), .node_result(node_result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4), .rsp_error(rsp_error4),
    .busy(busy4)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    step();
    step();
    #1;
    n_checks++;
    if ({req_ready, node_valid, node_op, node_arg, rsp_valid, rsp_data, rsp_error, busy} !== 80'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b nv=%b op=%0d arg=%h rv=%b data=%h err=%b busy=%b want all 0",
               req_ready, node_valid, node_op, node_arg, rsp_valid, rsp_data, rsp_error, busy);
    end
    n_checks++;
    if ({req_ready4, node_valid4, rsp_valid4, rsp_data4, rsp_error4, busy4} !== 43'h0) begin
      n_fail++;
      $display("FAIL reset_state_l4: got rv=%b data=%h busy=%b want all 0", rsp_valid4, rsp_data4, busy4);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 4'b0001; req_op[4:0] = 5'd3; req_arg[31:0] = 32'h0000_0042;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL rmw_grant: got %b want 0001", req_ready);
    end
    step();
    req_valid = 4'b0000;
    #1;
    n_checks++;
    if (node_valid !== 1'b1 || node_op !== 5'd3) begin
      n_fail++; $display("FAIL rmw_issue: got nv=%b op=%0d want nv=1 op=3", node_valid, node_op);
    end
    step();
    val1  = 32'h0000_0055;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({node_valid, node_op, node_arg, rsp_valid, rsp_data, rsp_error, busy, req_ready} !== 80'h0) begin
      n_fail++;
      $display("FAIL rmw_async_clear: got nv=%b op=%0d arg=%h rv=%b data=%h busy=%b want all 0",
               node_valid, node_op, node_arg, rsp_valid, rsp_data, busy);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0 || rsp_data !== 32'h0) begin
        n_fail++;
        $display("FAIL rmw_no_delivery: cycle %0d got rv=%b busy=%b data=%h want 0/0/0", c, rsp_valid, busy, rsp_data);
      end
    end
  endtask

  task automatic test_single_read();
    int nv0;
    apply_reset();
    nv0 = nv_count;
    val1 = 32'h0000_00AB;
    req_valid = 4'b0100; req_op[14:10] = 5'd3; req_arg[95:64] = 32'h0000_0010;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100 || node_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL read_accept: got rdy=%b nv=%b busy=%b want 0100/0/0", req_ready, node_valid, busy);
    end
    step();
    req_valid = 4'b0000;
    #1;
    n_checks++;
    if (node_valid !== 1'b1 || node_op !== 5'd3 || node_arg !== 32'h10 || busy !== 1'b1 || rsp_valid !== 4'b0) begin
      n_fail++;
      $display("FAIL read_issue: got nv=%b op=%0d arg=%h busy=%b rv=%b want 1/3/10/1/0000", node_valid, node_op, node_arg, busy, rsp_valid);
    end
    step();
    n_checks++;
    if (node_valid !== 1'b0 || rsp_valid !== 4'b0 || node_op !== 5'd3) begin
      n_fail++; $display("FAIL read_wait: got nv=%b rv=%b op=%0d want 0/0000/3", node_valid, rsp_valid, node_op);
    end
    step();
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'hAB || rsp_error !== 1'b0) begin
      n_fail++; $display("FAIL read_respond: got rv=%b data=%h err=%b want 0100/ab/0", rsp_valid, rsp_data, rsp_error);
    end
    step();
    rsp_ready = 4'b0100;
    #1;
    n_checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'hAB || busy !== 1'b1) begin
      n_fail++; $display("FAIL read_hold: got rv=%b data=%h busy=%b want 0100/ab/1", rsp_valid, rsp_data, busy);
    end
    step();
    rsp_ready = 4'b0000;
    n_checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || nv_count !== nv0 + 1) begin
      n_fail++; $display("FAIL read_done: got rv=%b busy=%b pulses=%0d want 0000/0/%0d", rsp_valid, busy, nv_count - nv0, 1);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [0:8];
    logic [3:0] got;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100; exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001; exp_seq[5] = 4'b0010; exp_seq[6] = 4'b1000; exp_seq[7] = 4'b0010;
    exp_seq[8] = 4'b1000;
    apply_reset();
    val1 = 32'h0000_1234;
    rsp_ready = 4'b1111;
    req_op = {5'd4, 5'd4, 5'd4, 5'd4};
    req_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      got = 4'b0000;
      for (int c = 0; c < 12 && got == 4'b0000; c++) begin
        #1;
        if (|req_ready) got = req_ready;
        else step();
      end
      n_checks++;
      if (got !== exp_seq[k]) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, got, exp_seq[k]);
      end
      step();
      if (k == 4) req_valid = 4'b1010;
    end
    req_valid = 4'b0000;
    for (int c = 0; c < 4; c++) step();
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 4'b0 || rsp_data !== 32'h1234) begin
      n_fail++; $display("FAIL rr_drain: got busy=%b rv=%b data=%h want 0/0000/1234", busy, rsp_valid, rsp_data);
    end
  endtask

  task automatic test_invalid_op();
    logic [4:0] bad [0:1];
    int nv0;
    bad[0] = 5'd0; bad[1] = 5'd31;
    nv0 = nv_count;
    rsp_ready = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      req_valid = 4'b0010; req_op[9:5] = bad[k];
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
        n_fail++; $display("FAIL inv_accept_%0d: got %b want 0010", k, req_ready);
      end
      step();
      req_valid = 4'b0000;
      rsp_ready = 4'b0010;
      #1;
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_error !== 1'b1 || rsp_data !== 32'h0 || node_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_respond_%0d: got rv=%b err=%b data=%h nv=%b want 0010/1/0/0", k, rsp_valid, rsp_error, rsp_data, node_valid);
      end
      step();
      rsp_ready = 4'b0000;
      n_checks++;
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
        n_fail++; $display("FAIL inv_done_%0d: got rv=%b busy=%b want 0000/0", k, rsp_valid, busy);
      end
    end
    n_checks++;
    if (nv_count !== nv0) begin
      n_fail++; $display("FAIL inv_no_node: got %0d node pulses want 0", nv_count - nv0);
    end
  endtask

  task automatic test_backpressure();
    val1 = 32'h0000_00C3;
    rsp_ready = 4'b0000;
    req_valid = 4'b1000; req_op[19:15] = 5'd3; req_op[4:0] = 5'd4;
    #1;
    n_checks++;
    if (req_ready !== 4'b1000) begin
      n_fail++; $display("FAIL bp_accept: got %b want 1000", req_ready);
    end
    step();
    req_valid = 4'b0001;
    step();
    step();
    rsp_ready = 4'b0111;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++;
      if (rsp_valid !== 4'b1000 || rsp_data !== 32'hC3 || rsp_error !== 1'b0 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got rv=%b data=%h err=%b rdy=%b want 1000/c3/0/0000", c, rsp_valid, rsp_data, rsp_error, req_ready);
      end
      step();
    end
    rsp_ready = 4'b1000;
    #1;
    n_checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b1000) begin
      n_fail++; $display("FAIL bp_handshake: got rdy=%b rv=%b want 0000/1000", req_ready, rsp_valid);
    end
    step();
    rsp_ready = 4'b0000;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin
      n_fail++; $display("FAIL bp_next_accept: got rdy=%b rv=%b want 0001/0000", req_ready, rsp_valid);
    end
    step();
    req_valid = 4'b0000;
    rsp_ready = 4'b1111;
    for (int c = 0; c < 4; c++) step();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_latency4();
    val4 = 32'h0000_9999;
    req_valid4 = 4'b0001; req_op4[4:0] = 5'd2; req_arg4[31:0] = 32'h0000_0077;
    #1;
    n_checks++;
    if (req_ready4 !== 4'b0001 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL l4_accept: got rdy=%b busy=%b want 0001/0", req_ready4, busy4);
    end
    step();
    req_valid4 = 4'b0000;
    #1;
    n_checks++;
    if (node_valid4 !== 1'b1 || node_op4 !== 5'd2 || node_arg4 !== 32'h77 || busy4 !== 1'b1) begin
      n_fail++; $display("FAIL l4_issue: got nv=%b op=%0d arg=%h busy=%b want 1/2/77/1", node_valid4, node_op4, node_arg4, busy4);
    end
    for (int c = 2; c <= 5; c++) begin
      step();
      n_checks++;
      if (node_valid4 !== 1'b0 || rsp_valid4 !== 4'b0000 || busy4 !== 1'b1) begin
        n_fail++; $display("FAIL l4_wait_t%0d: got nv=%b rv=%b busy=%b want 0/0000/1", c, node_valid4, rsp_valid4, busy4);
      end
    end
    step();
    rsp_ready4 = 4'b0001;
    #1;
    n_checks++;
    if (rsp_valid4 !== 4'b0001 || rsp_data4 !== 32'h9999 || rsp_error4 !== 1'b0 || busy4 !== 1'b1) begin
      n_fail++; $display("FAIL l4_respond: got rv=%b data=%h err=%b busy=%b want 0001/9999/0/1", rsp_valid4, rsp_data4, rsp_error4, busy4);
    end
    step();
    rsp_ready4 = 4'b0000;
    n_checks++;
    if (rsp_valid4 !== 4'b0000 || busy4 !== 1'b0) begin
      n_fail++; $display("FAIL l4_done: got rv=%b busy=%b want 0000/0", rsp_valid4, busy4);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_wait();
    test_single_read();
    test_round_robin();
    test_invalid_op();
    test_backpressure();
    test_latency4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
